// File: rtl/branch_predictor_pkg.sv
// Shared branch-predictor types: address/word types, BTB entry layout,
// 2-bit direction-counter states and the fetch reset vector.
// Pure declarations: no latency, no flow control.
package branch_predictor_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  // Stored tag field is sized for the widest legal tag (32 - 2 byte bits
  // - at least 1 index bit); narrower TAG_W settings keep the upper bits 0.
  localparam int TAG_MAX_W = 29;

  localparam virt_t RESET_VECTOR = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,  // strong not-taken
    CNT_WNT = 2'b01,  // weak not-taken
    CNT_WT  = 2'b10,  // weak taken
    CNT_ST  = 2'b11   // strong taken
  } bp_cnt_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    virt_t                target;
    bp_cnt_e              cnt;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating direction counter next-state function.
// Purely combinational (0 cycles); no flow control.
// Ports: cnt (current state), taken (resolved direction), cnt_next (new state).
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  bp_cnt_e cnt,
  input  logic    taken,
  output bp_cnt_e cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != CNT_ST) cnt_next = bp_cnt_e'(cnt + 2'd1);
    end else begin
      if (cnt != CNT_SNT) cnt_next = bp_cnt_e'(cnt - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, mispredict redirect and perf counters.
// Lookup is 0-cycle combinational; updates, redirect and counters land on the next edge.
// No backpressure: one update accepted per cycle, redirect is a fire-and-forget pulse.
// Ports: clk/resetn; if_valid/if_pc -> predict_is_taken/predict_target;
//        upd_* resolution inputs and flush; redirect_valid/redirect_pc; perf_branches/perf_mispredicts.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int      ENTRIES   = 16,
  parameter int      TAG_W     = 10,
  // Reset value of both performance counters (0 in normal use).
  parameter uint32_t PERF_INIT = 32'd0
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    if_valid,
  input  virt_t   if_pc,
  output logic    predict_is_taken,
  output virt_t   predict_target,
  input  logic    upd_valid,
  input  virt_t   upd_pc,
  input  logic    upd_taken,
  input  virt_t   upd_target,
  input  logic    upd_success,
  input  logic    flush,
  output logic    redirect_valid,
  output virt_t   redirect_pc,
  output uint32_t perf_branches,
  output uint32_t perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  function automatic logic [TAG_MAX_W-1:0] tag_of(input virt_t pc);
    logic [TAG_MAX_W-1:0] t;
    t = '0;
    t[TAG_W-1:0] = pc[2+IDX_W +: TAG_W];
    return t;
  endfunction

  btb_entry_t btb [ENTRIES];

  // ---------------- lookup (reads current flops, so same-cycle updates are not visible)
  logic [IDX_W-1:0] rd_idx;
  btb_entry_t       rd_entry;
  logic             rd_hit;

  assign rd_idx           = if_pc[2 +: IDX_W];
  assign rd_entry         = btb[rd_idx];
  assign rd_hit           = rd_entry.valid && (rd_entry.tag == tag_of(if_pc));
  assign predict_is_taken = if_valid && rd_hit && rd_entry.cnt[1];
  assign predict_target   = rd_hit ? rd_entry.target : if_pc + 32'd8;

  // ---------------- update
  logic             accept;
  logic             mispredict;
  logic [IDX_W-1:0] wr_idx;
  btb_entry_t       wr_old;
  btb_entry_t       wr_new;
  logic             wr_hit;
  logic             wr_en;
  bp_cnt_e          cnt_next;

  assign accept     = upd_valid && !flush;
  assign mispredict = accept && !upd_success;
  assign wr_idx     = upd_pc[2 +: IDX_W];
  assign wr_old     = btb[wr_idx];
  assign wr_hit     = wr_old.valid && (wr_old.tag == tag_of(upd_pc));

  sat_counter2 u_cnt (
    .cnt      (wr_old.cnt),
    .taken    (upd_taken),
    .cnt_next (cnt_next)
  );

  always_comb begin
    wr_en  = 1'b0;
    wr_new = wr_old;
    if (accept) begin
      if (wr_hit) begin
        wr_en      = 1'b1;
        wr_new.cnt = cnt_next;
        if (upd_taken) wr_new.target = upd_target;
      end else if (upd_taken) begin
        // Allocation evicts whatever aliased entry lived at this index.
        wr_en         = 1'b1;
        wr_new.valid  = 1'b1;
        wr_new.tag    = tag_of(upd_pc);
        wr_new.target = upd_target;
        wr_new.cnt    = CNT_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};
      end
    end else if (wr_en) begin
      btb[wr_idx] <= wr_new;
    end
  end

  // ---------------- redirect and performance counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_valid   <= 1'b0;
      redirect_pc      <= RESET_VECTOR;
      perf_branches    <= PERF_INIT;
      perf_mispredicts <= PERF_INIT;
    end else begin
      redirect_valid <= mispredict;
      // Not-taken restart skips the branch and its always-executed delay slot.
      if (mispredict) redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd8;
      if (accept)     perf_branches <= perf_branches + 32'd1;
      if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

  // PC bits outside index/tag and the counter's low bit on the lookup side carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{if_pc, upd_pc, rd_entry.cnt[0]};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int ENT = 16;

  logic    clk;
  logic    resetn;
  logic    if_valid;
  virt_t   if_pc;
  logic    predict_is_taken;
  virt_t   predict_target;
  logic    upd_valid;
  virt_t   upd_pc;
  logic    upd_taken;
  virt_t   upd_target;
  logic    upd_success;
  logic    flush;
  logic    redirect_valid;
  virt_t   redirect_pc;
  uint32_t perf_branches;
  uint32_t perf_mispredicts;

  // second instance with preset perf counters, used for wrap-around
  logic    w_upd_valid;
  logic    w_upd_success;
  logic    w_predict_is_taken;
  virt_t   w_predict_target;
  logic    w_redirect_valid;
  virt_t   w_redirect_pc;
  uint32_t w_perf_branches;
  uint32_t w_perf_mispredicts;

  int errors;
  int checks;

  // ---------------- behavioural reference model
  bit          m_valid [ENT];
  logic [31:0] m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_cnt   [ENT];
  logic        e_rv;
  logic [31:0] e_rpc;
  logic [31:0] e_br;
  logic [31:0] e_mp;

  branch_predictor dut (
    .clk              (clk),
    .resetn           (resetn),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .predict_is_taken (predict_is_taken),
    .predict_target   (predict_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_success      (upd_success),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  branch_predictor #(.PERF_INIT(32'hFFFF_FFFE)) dut_wrap (
    .clk              (clk),
    .resetn           (resetn),
    .if_valid         (1'b0),
    .if_pc            (32'h0),
    .predict_is_taken (w_predict_is_taken),
    .predict_target   (w_predict_target),
    .upd_valid        (w_upd_valid),
    .upd_pc           (32'h8000_0000),
    .upd_taken        (1'b0),
    .upd_target       (32'h0),
    .upd_success      (w_upd_success),
    .flush            (1'b0),
    .redirect_valid   (w_redirect_valid),
    .redirect_pc      (w_redirect_pc),
    .perf_branches    (w_perf_branches),
    .perf_mispredicts (w_perf_mispredicts)
  );

  always #5 clk = ~clk;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return (pc >> 6) & 32'h3FF;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic logic m_pred_taken(input logic v, input logic [31:0] pc);
    return v && m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[m_idx(pc)] : pc + 32'd8;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_cnt[i]   = 1;
    end
    e_rv  = 1'b0;
    e_rpc = 32'hBFC0_0000;
    e_br  = '0;
    e_mp  = '0;
  endtask

  // Advance one clock; the model absorbs whatever update was driven before the edge.
  task automatic tick();
    logic        sv, st, ss, sf;
    logic [31:0] spc, stg;
    int          i;
    sv = upd_valid; st = upd_taken; ss = upd_success; sf = flush;
    spc = upd_pc; stg = upd_target;
    @(posedge clk);
    #1;
    e_rv = 1'b0;
    if (sv && !sf) begin
      i = m_idx(spc);
      if (m_hit(spc)) begin
        if (st) begin
          if (m_cnt[i] < 3) m_cnt[i] = m_cnt[i] + 1;
          m_tgt[i] = stg;
        end else if (m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end else if (st) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = m_tagof(spc);
        m_tgt[i]   = stg;
        m_cnt[i]   = 2;
      end
      e_br = e_br + 32'd1;
      if (!ss) begin
        e_mp  = e_mp + 32'd1;
        e_rv  = 1'b1;
        e_rpc = st ? stg : spc + 32'd8;
      end
    end
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                           input logic succ);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_success = succ;
  endtask

  // ---------------- tests
  task automatic test_reset();
    if_valid = 1'b1;
    if_pc    = 32'h8000_0100;
    #1;
    checks++;
    if (predict_is_taken !== 1'b0) begin
      errors++; $display("FAIL reset_held_taken: got %b want 0", predict_is_taken);
    end
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    checks++;
    if (predict_is_taken !== 1'b0 || predict_target !== 32'h8000_0108) begin
      errors++; $display("FAIL reset_lookup: got %b/%h want 0/80000108", predict_is_taken, predict_target);
    end
    checks++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'hBFC0_0000) begin
      errors++; $display("FAIL reset_redirect: got %b/%h want 0/bfc00000", redirect_valid, redirect_pc);
    end
    checks++;
    if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin
      errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_branches, perf_mispredicts);
    end
  endtask

  task automatic test_counter();
    drive_upd(32'h8000_0100, 1'b1, 32'h8000_0200, 1'b0);
    tick();
    upd_valid = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0200) begin
      errors++; $display("FAIL alloc_redirect: got %b/%h want 1/80000200", redirect_valid, redirect_pc);
    end
    checks++;
    if (predict_is_taken !== 1'b1 || predict_target !== 32'h8000_0200) begin
      errors++; $display("FAIL alloc_lookup: got %b/%h want 1/80000200", predict_is_taken, predict_target);
    end
    checks++;
    if (perf_mispredicts !== 32'd1 || perf_branches !== 32'd1) begin
      errors++; $display("FAIL alloc_perf: got %0d/%0d want 1/1", perf_branches, perf_mispredicts);
    end
    for (int k = 0; k < 3; k++) begin
      drive_upd(32'h8000_0100, 1'b1, 32'h8000_0200, 1'b1);
      tick();
    end
    upd_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h8000_0200 || perf_branches !== 32'd4) begin
      errors++; $display("FAIL taken_run: got %b/%h/%0d want 0/80000200/4", redirect_valid, redirect_pc, perf_branches);
    end
    drive_upd(32'h8000_0100, 1'b0, 32'h0, 1'b0);
    tick();
    upd_valid = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0108) begin
      errors++; $display("FAIL nt_redirect: got %b/%h want 1/80000108", redirect_valid, redirect_pc);
    end
    checks++;
    if (predict_is_taken !== 1'b1) begin
      errors++; $display("FAIL sat_one_nt: got %b want 1", predict_is_taken);
    end
    drive_upd(32'h8000_0100, 1'b0, 32'h0, 1'b1);
    tick();
    upd_valid = 1'b0;
    #1;
    checks++;
    if (predict_is_taken !== 1'b0 || predict_target !== 32'h8000_0200) begin
      errors++; $display("FAIL sat_two_nt: got %b/%h want 0/80000200", predict_is_taken, predict_target);
    end
    checks++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h8000_0108 || perf_mispredicts !== 32'd2) begin
      errors++; $display("FAIL nt_hold: got %b/%h/%0d want 0/80000108/2", redirect_valid, redirect_pc, perf_mispredicts);
    end
  endtask

  task automatic test_alias();
    drive_upd(32'h8000_0100 + ENT * 4, 1'b1, 32'h8000_0300, 1'b1);
    tick();
    upd_valid = 1'b0;
    if_pc = 32'h8000_0100;
    #1;
    checks++;
    if (predict_is_taken !== 1'b0 || predict_target !== 32'h8000_0108) begin
      errors++; $display("FAIL alias_evicted: got %b/%h want 0/80000108", predict_is_taken, predict_target);
    end
    if_pc = 32'h8000_0100 + ENT * 4;
    #1;
    checks++;
    if (predict_is_taken !== 1'b1 || predict_target !== 32'h8000_0300) begin
      errors++; $display("FAIL alias_new: got %b/%h want 1/80000300", predict_is_taken, predict_target);
    end
  endtask

  task automatic test_flush();
    logic [31:0] br0, mp0;
    br0 = perf_branches; mp0 = perf_mispredicts;
    if_pc = 32'h8000_0400;
    drive_upd(32'h8000_0400, 1'b1, 32'h8000_0500, 1'b0);
    flush = 1'b1;
    tick();
    upd_valid = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || perf_branches !== br0 || perf_mispredicts !== mp0) begin
      errors++; $display("FAIL flush_cancel: got %b/%0d/%0d want 0/%0d/%0d", redirect_valid, perf_branches, perf_mispredicts, br0, mp0);
    end
    checks++;
    if (predict_is_taken !== 1'b0 || predict_target !== 32'h8000_0408) begin
      errors++; $display("FAIL flush_nowrite: got %b/%h want 0/80000408", predict_is_taken, predict_target);
    end
    // redirect registered, then reset lands immediately after
    if_pc = 32'h8000_0140;
    drive_upd(32'h8000_0140, 1'b1, 32'h8000_0700, 1'b0);
    tick();
    upd_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0700) begin
      errors++; $display("FAIL pre_reset_redirect: got %b/%h want 1/80000700", redirect_valid, redirect_pc);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'hBFC0_0000) begin
      errors++; $display("FAIL async_reset_redirect: got %b/%h want 0/bfc00000", redirect_valid, redirect_pc);
    end
    checks++;
    if (predict_is_taken !== 1'b0 || perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin
      errors++; $display("FAIL async_reset_state: got %b/%0d/%0d want 0/0/0", predict_is_taken, perf_branches, perf_mispredicts);
    end
    model_reset();
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_same_cycle();
    if_valid = 1'b1;
    if_pc = 32'h8000_0500;
    drive_upd(32'h8000_0500, 1'b1, 32'h8000_0600, 1'b0);
    #1;
    checks++;
    if (predict_is_taken !== 1'b0 || predict_target !== 32'h8000_0508) begin
      errors++; $display("FAIL same_cycle_old: got %b/%h want 0/80000508", predict_is_taken, predict_target);
    end
    tick();
    upd_valid = 1'b0;
    #1;
    checks++;
    if (predict_is_taken !== 1'b1 || predict_target !== 32'h8000_0600) begin
      errors++; $display("FAIL same_cycle_new: got %b/%h want 1/80000600", predict_is_taken, predict_target);
    end
  endtask

  function automatic logic [31:0] pick_pc();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC;
    return 32'h8000_0000 | ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2);
  endfunction

  task automatic test_random();
    logic [31:0] tg;
    for (int n = 0; n < 400; n++) begin
      if_valid    = ($urandom_range(0, 3) != 0);
      if_pc       = pick_pc();
      upd_valid   = ($urandom_range(0, 2) != 0);
      upd_pc      = pick_pc();
      upd_taken   = 1'($urandom_range(0, 1));
      tg          = $urandom;
      upd_target  = {tg[31:2], 2'b00};
      upd_success = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (predict_is_taken !== m_pred_taken(if_valid, if_pc) || predict_target !== m_pred_target(if_pc)) begin
        errors++;
        $display("FAIL rnd_lookup pc=%h: got %b/%h want %b/%h", if_pc, predict_is_taken, predict_target,
                 m_pred_taken(if_valid, if_pc), m_pred_target(if_pc));
      end
      tick();
      checks++;
      if (redirect_valid !== e_rv || redirect_pc !== e_rpc) begin
        errors++; $display("FAIL rnd_redirect: got %b/%h want %b/%h", redirect_valid, redirect_pc, e_rv, e_rpc);
      end
      checks++;
      if (perf_branches !== e_br || perf_mispredicts !== e_mp) begin
        errors++; $display("FAIL rnd_perf: got %0d/%0d want %0d/%0d", perf_branches, perf_mispredicts, e_br, e_mp);
      end
    end
    upd_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_br;
    exp_br = 32'hFFFF_FFFE;
    checks++;
    if (w_perf_branches !== exp_br) begin
      errors++; $display("FAIL wrap_preset: got %h want %h", w_perf_branches, exp_br);
    end
    w_upd_valid = 1'b1;
    w_upd_success = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_br = exp_br + 32'd1;
      checks++;
      if (w_perf_branches !== exp_br || w_perf_mispredicts !== 32'hFFFF_FFFE) begin
        errors++; $display("FAIL wrap_step%0d: got %h/%h want %h/fffffffe", k, w_perf_branches, w_perf_mispredicts, exp_br);
      end
    end
    w_upd_valid = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    clk = 1'b0; resetn = 1'b1;
    if_valid = 1'b0; if_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_success = 1'b1;
    flush = 1'b0; w_upd_valid = 1'b0; w_upd_success = 1'b1;
    #2;
    resetn = 1'b0;
    model_reset();
    test_reset();
    test_counter();
    test_alias();
    test_flush();
    test_same_cycle();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters, plus the mispredict redirect sequencer. Sits beside the fetch stage: it supplies `predict_is_taken`/`predict_target` for the fetching PC and consumes branch resolution results from the EXE branch-control logic. On a misprediction it issues a one-cycle registered redirect to fetch. It also keeps branch/mispredict performance counters.

## Interface
- `ENTRIES`, 16: BTB entries, power of two; `IDX_W = $clog2(ENTRIES)`.
- `TAG_W`, 10: stored tag width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `if_valid`  in  1  fetch PC is valid this cycle.
- `if_pc`  in  virt_t  fetching PC.
- `predict_is_taken`  out  1  combinational: BTB hit and counter[1] set, gated by `if_valid`.
- `predict_target`  out  virt_t  combinational: stored target on a hit, else `if_pc + 8`.
- `upd_valid`  in  1  a branch/jump resolved in EXE this cycle.
- `upd_pc`  in  virt_t  PC of the resolved branch.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  virt_t  actual target when taken.
- `upd_success`  in  1  prediction made for this branch was correct.
- `flush`  in  1  exception/eret flush; cancels this cycle's update and any pending redirect.
- `redirect_valid`  out  1  registered one-cycle pulse: fetch must restart.
- `redirect_pc`  out  virt_t  registered restart PC.
- `perf_branches`  out  32  resolved branch count.
- `perf_mispredicts`  out  32  mispredict count.

## Operation
- Index is `pc[2 +: IDX_W]`. Tag is `pc[2+IDX_W +: TAG_W]`. Each entry holds valid, tag, target (virt_t), and a 2-bit counter.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is a read of the flop array and is combinational. Hit means valid and tag match. The prediction is taken when the entry hits and counter[1] is set.
- Update happens when `upd_valid && !flush`:
  - Hit: counter saturating-increments if taken, saturating-decrements if not taken. Target is overwritten when taken.
  - Miss and taken: allocate the entry with valid=1, the new tag, `upd_target`, and counter 10, replacing any occupant.
  - Miss and not taken: no write.
- Redirect happens when `upd_valid && !upd_success && !flush`. On the next edge `redirect_valid` is 1 and `redirect_pc` is `upd_target` if taken, else `upd_pc + 8` (the delay slot is always executed). Otherwise `redirect_valid` is 0 and `redirect_pc` holds its value.
- `flush` has priority over update: no BTB write, no counter change, no redirect, no perf increment that cycle.
- Perf counters:
  - `perf_branches` increments on every accepted update.
  - `perf_mispredicts` increments on every accepted update with `!upd_success`.
  - Both wrap modulo 2^32.

## Timing
- Prediction has 0-cycle latency from `if_pc`. Update and redirect take effect at the next rising edge.
- Simultaneous lookup and update to the same index: the lookup sees the pre-update contents. A new value becomes visible the cycle after the edge.
- Back-to-back updates are accepted every cycle. Each mispredict produces its own one-cycle pulse. There is no handshake; fetch must accept `redirect_valid` unconditionally.
- Reset, applied asynchronously at any time including mid-update:
  - All valid bits cleared and counters set to 01.
  - `redirect_valid` 0, `redirect_pc` 0xBFC00000.
  - Perf counters 0.
  - `predict_is_taken` is 0 while reset is held.
- Arithmetic is 32-bit unsigned. `pc + 8` wraps at 2^32.

## Structure
- `virt_t` and `uint32_t` come from `cpu_defs.svh`. Add to the shared package:
  - a `btb_entry_t` packed struct (valid, tag, target, cnt);
  - a `bp_cnt_e` enum for the four counter states;
  - the reset-vector constant.
- One sub-module, `sat_counter2`: a combinational 2-bit saturating next-state function taking cnt and taken. It is instantiated once on the update path.

## Test plan
- Reset, then lookup `if_pc=0x80000100` with `if_valid=1` -> `predict_is_taken=0`, `predict_target=0x80000108`. Perf counters are 0.
- Update `pc=0x80000100`, taken, target 0x80000200, `upd_success=0` -> next cycle `redirect_valid=1`, `redirect_pc=0x80000200`. Lookup then gives taken with target 0x80000200, and `perf_mispredicts=1`.
- Three more taken updates on 0x80000100 -> counter saturates at 11. Two not-taken updates -> counter 01, prediction not-taken, and the first of those redirects to 0x80000108.
- Aliasing: 0x80000100 allocated, then taken update on `0x80000100 + (ENTRIES*4)` -> entry replaced; the original PC now misses.
- `flush=1` with a mispredicting update -> no redirect, no BTB change, perf counters unchanged. Also: `resetn` dropped the cycle a redirect is registered -> `redirect_valid=0` immediately.
- Same-cycle lookup and allocating update on the same PC -> lookup returns miss that cycle and hit the next. `perf_branches` preset near 0xFFFFFFFF wraps to 0.
